// File: rtl/shift_arb_pkg.sv
// Shared constants and types for the shift arbiter.
// Optional feature: define SHIFT_ARB_RR_EN for round-robin grant (default: fixed priority).
package shift_arb_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_AMT_W = 5;

  // Per-requester operation select
  localparam logic OP_SRA = 1'b0;
  localparam logic OP_SLL = 1'b1;

  // Response register state
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/shift_arb_rr.sv
// Grant selection for the shift arbiter.
// SHIFT_ARB_RR_EN defined: round-robin starting after ptr; undefined: lowest index wins.
module shift_arb_rr
  import shift_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any
);

`ifdef SHIFT_ARB_RR_EN
  logic [ID_W-1:0] idx;

  // Rotating search beginning one past the last granted requester
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NREQ);
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end
`else
  // Pointer has no effect in fixed-priority mode
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: lowest requesting index wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en && !gnt_any && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = ID_W'(i);
        gnt_any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates NREQ requesters onto one external SRA/SLL shifter pair and
// registers the selected result on a single tagged response channel.
// SHIFT_ARB_RR_EN selects round-robin grant; default build is fixed priority.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = DEF_AMT_W,
  parameter int unsigned ID_W  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0] req_amt,
  input  logic [NREQ-1:0]       req_op,
  output logic [WIDTH-1:0]      sh_dta,
  output logic [AMT_W-1:0]      sh_amt,
  input  logic [WIDTH-1:0]      sh_sra_res,
  input  logic [WIDTH-1:0]      sh_sll_res,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic [ID_W-1:0]       resp_id
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [ID_W-1:0]  ptr_c;
  logic             can_accept;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             op_sel;

`ifdef SHIFT_ARB_RR_EN
  logic [ID_W-1:0]  ptr_q, ptr_d;
  assign ptr_c = ptr_q;
`else
  assign ptr_c = '0;
`endif

  // Register is free, or being drained this cycle; never accept during reset
  assign can_accept = ~reset & ((state_q == IDLE) | resp_ready);

  shift_arb_rr #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_c),
    .en      (can_accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // One-hot operand mux; zero when nothing is granted to keep the shifters quiet
  always_comb begin
    sh_dta = '0;
    sh_amt = '0;
    op_sel = OP_SRA;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sh_dta = req_data[i*WIDTH +: WIDTH];
        sh_amt = req_amt[i*AMT_W +: AMT_W];
        op_sel = req_op[i];
      end
    end
  end

  // Next-state: capture on grant, otherwise drain to IDLE when consumed
  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
`ifdef SHIFT_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    if (gnt_any) begin
      resp_data_d = (op_sel == OP_SRA) ? sh_sra_res : sh_sll_res;
      resp_id_d   = gnt_idx;
      state_d     = HOLD;
`ifdef SHIFT_ARB_RR_EN
      ptr_d       = gnt_idx;
`endif
    end else if ((state_q == HOLD) && resp_ready) begin
      state_d = IDLE;
    end
  end

  // State and response registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      resp_data_q <= '0;
      resp_id_q   <= '0;
`ifdef SHIFT_ARB_RR_EN
      ptr_q       <= ID_W'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
`ifdef SHIFT_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign resp_valid = (state_q == HOLD);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized scoreboard bench for shift_arbiter with directed corner cases.
// Honors SHIFT_ARB_RR_EN the same way as the design.
module tb_shift_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AMT_W = 5;
  localparam int unsigned ID_W  = 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*AMT_W-1:0] req_amt;
  logic [NREQ-1:0]       req_op;
  logic [WIDTH-1:0]      sh_dta;
  logic [AMT_W-1:0]      sh_amt;
  logic [WIDTH-1:0]      sh_sra_res;
  logic [WIDTH-1:0]      sh_sll_res;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [ID_W-1:0]       resp_id;

  always #5 clock = ~clock;

  // External shifter datapath
  assign sh_sra_res = WIDTH'($signed(sh_dta) >>> sh_amt);
  assign sh_sll_res = sh_dta << sh_amt;

  shift_arbiter #(
    .NREQ (NREQ), .WIDTH (WIDTH), .AMT_W (AMT_W), .ID_W (ID_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_op     (req_op),
    .sh_dta     (sh_dta),
    .sh_amt     (sh_amt),
    .sh_sra_res (sh_sra_res),
    .sh_sll_res (sh_sll_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [ID_W-1:0]  id;
  } exp_t;

  exp_t sb[$];
  bit   m_busy;
  int   m_last;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input bit op);
    logic signed [31:0] s;
    s = d;
    if (op) return d << a;
    return 32'(s >>> a);
  endfunction

  task automatic set_req(input int i, input bit v, input logic [31:0] d, input int a, input bit op);
    req_valid[i]              = v;
    req_data[i*WIDTH +: WIDTH] = d;
    req_amt[i*AMT_W +: AMT_W] = AMT_W'(a);
    req_op[i]                 = op;
  endtask

  // One clock: apply controls, predict grant at negedge, advance to posedge+1
  task automatic step(input bit rr, input bit rst);
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [31:0]     exp_dta;
    int              exp_amt;
    resp_ready = rr;
    reset      = rst;
    @(negedge clock);
    g = -1;
    if (!rst && (!m_busy || rr)) begin
`ifdef SHIFT_ARB_RR_EN
      for (int k = 1; k <= int'(NREQ); k++) begin
        int idx = (m_last + k) % int'(NREQ);
        if (g < 0 && req_valid[idx]) g = idx;
      end
`else
      for (int i = 0; i < int'(NREQ); i++)
        if (g < 0 && req_valid[i]) g = i;
`endif
    end
    exp_ready = '0;
    exp_dta   = '0;
    exp_amt   = 0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_dta      = req_data[g*WIDTH +: WIDTH];
      exp_amt      = int'(req_amt[g*AMT_W +: AMT_W]);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("resp_valid", 32'(resp_valid), 32'(m_busy));
    chk("sh_dta", sh_dta, exp_dta);
    chk("sh_amt", 32'(sh_amt), 32'(exp_amt));
    if (rst) begin
      m_busy = 1'b0;
      m_last = int'(NREQ) - 1;
      sb.delete();
    end else if (g >= 0) begin
      sb.push_back({ref_shift(exp_dta, exp_amt, req_op[g]), ID_W'(g)});
      m_busy = 1'b1;
      m_last = g;
    end else if (rr) begin
      m_busy = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_resp(input string name, input bit v, input logic [31:0] d, input int id);
    chk({name, "_valid"}, 32'(resp_valid), 32'(v));
    chk({name, "_data"}, resp_data, d);
    chk({name, "_id"}, 32'(resp_id), 32'(id));
  endtask

  // Monitor: every presented response must match the scoreboard head
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && resp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL resp_unexpected: got data %h id %0d expected no response", resp_data, resp_id);
        end else begin
          chk("sb_data", resp_data, sb[0].data);
          chk("sb_id", 32'(resp_id), 32'(sb[0].id));
          if (resp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    reset      = 1'b1;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_amt    = '0;
    req_op     = '0;
    m_busy     = 1'b0;
    m_last     = int'(NREQ) - 1;
    @(posedge clock);
    #1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk_resp("reset", 1'b0, 32'h0, 0);

    // Single request
    set_req(0, 1'b1, 32'h8000_0000, 4, 1'b0);
    step(1'b1, 1'b0);
    set_req(0, 1'b0, 32'h0, 0, 1'b0);
    chk_resp("single", 1'b1, 32'hF800_0000, 0);
    step(1'b1, 1'b0);
    chk_resp("idle_keep", 1'b0, 32'hF800_0000, 0);

    // Boundary values, back-to-back on requester 0
    set_req(0, 1'b1, 32'h7FFF_FFFF, 31, 1'b0); step(1'b1, 1'b0);
    chk_resp("sra31_pos", 1'b1, 32'h0000_0000, 0);
    set_req(0, 1'b1, 32'h8000_0000, 31, 1'b0); step(1'b1, 1'b0);
    chk_resp("sra31_neg", 1'b1, 32'hFFFF_FFFF, 0);
    set_req(0, 1'b1, 32'h1234_5678, 0, 1'b1); step(1'b1, 1'b0);
    chk_resp("sll0_echo", 1'b1, 32'h1234_5678, 0);
    set_req(0, 1'b1, 32'h9ABC_DEF0, 0, 1'b0); step(1'b1, 1'b0);
    chk_resp("sra0_echo", 1'b1, 32'h9ABC_DEF0, 0);
    set_req(0, 1'b0, 32'h0, 0, 1'b0); step(1'b1, 1'b0);

    // Contention from a fresh reset
    set_req(0, 1'b1, 32'h8000_0000, 4, 1'b0);
    set_req(1, 1'b1, 32'h0000_0001, 31, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
`ifdef SHIFT_ARB_RR_EN
      if (k % 2 == 1) chk_resp("contend", 1'b1, 32'h8000_0000, 1);
      else            chk_resp("contend", 1'b1, 32'hF800_0000, 0);
`else
      chk_resp("contend", 1'b1, 32'hF800_0000, 0);
`endif
    end

    // Backpressure: held response stays stable, no grants
`ifdef SHIFT_ARB_RR_EN
    held = 32'h8000_0000;
`else
    held = 32'hF800_0000;
`endif
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      chk("bp_data", resp_data, held);
    end
    step(1'b1, 1'b0);
    chk_resp("bp_release", 1'b1, 32'hF800_0000, 0);

    // Reset while holding a response
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk_resp("rst_hold", 1'b0, 32'h0, 0);
    step(1'b1, 1'b0);
    chk_resp("post_rst", 1'b1, 32'hF800_0000, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        logic [31:0] d;
        case ($urandom_range(0, 7))
          0:       d = 32'h8000_0000;
          1:       d = 32'h7FFF_FFFF;
          default: d = $urandom;
        endcase
        set_req(i, ($urandom_range(0, 2) != 0), d, int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255) == 0);
    end

    // Drain
    req_valid = '0;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath between NREQ requesters, e.g. ALU issue and multi-cycle mul/div.
- The datapath sits outside this block: one arithmetic-right-shift instance and one logical-left-shift instance. This block drives their inputs and selects their outputs.
- Per-requester valid/ready request handshake; one registered response channel tagged with requester id.
- Round-robin grant, one-cycle latency, full throughput under continuous resp_ready.

Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 32, data width; must match shifter width
- AMT_W, 5, shift-amount width (log2 WIDTH)
- ID_W, 1, response id width (clog2 NREQ, minimum 1)

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_data  in  NREQ*WIDTH  operand; requester i occupies bits [i*WIDTH +: WIDTH]
- req_amt  in  NREQ*AMT_W  shift amount per requester
- req_op  in  NREQ  per requester: 0 = SRA, 1 = SLL
- sh_dta  out  WIDTH  operand to both shifters
- sh_amt  out  AMT_W  amount to both shifters
- sh_sra_res  in  WIDTH  combinational SRA result
- sh_sll_res  in  WIDTH  combinational SLL result
- resp_valid  out  1  response held
- resp_ready  in  1  consumer accepts response
- resp_data  out  WIDTH  registered shift result
- resp_id  out  ID_W  index of the requester that issued the result

Behaviour:
- States:
  - IDLE: no response held.
  - HOLD: response registered; resp_valid=1.
- Accept enable: can_accept = (state==IDLE) | resp_ready.
- Grant:
  - When can_accept and any req_valid, exactly one requester g is granted.
  - req_ready[g]=1 combinationally in that cycle; all other req_ready bits are 0.
  - When can_accept=0 or no req_valid, req_ready is all zero.
- Round-robin:
  - Search starts at ptr+1 mod NREQ.
  - ptr updates to g only on a grant.
  - ptr resets to NREQ-1, so requester 0 wins first.
- Shifter drive:
  - With a grant: sh_dta=req_data[g], sh_amt=req_amt[g].
  - Without a grant: both driven to 0 (no spurious toggling).
- On grant, at the posedge:
  - resp_data <= (req_op[g] ? sh_sll_res : sh_sra_res)
  - resp_id <= g
  - state <= HOLD
- Latency: accepted at edge k -> resp_valid at cycle k+1.
- HOLD with resp_ready=0: resp_data and resp_id stay stable; no grants.
- HOLD with resp_ready=1:
  - A new grant refills the register the same cycle; state stays HOLD (back-to-back).
  - With no new grant, state returns to IDLE and resp_valid=0.
- resp_data and resp_id are not cleared on return to IDLE; they keep their last value.
- Amount 0 returns the operand unchanged. Amount 31 SRA yields 0x00000000 or 0xFFFFFFFF depending on the sign bit. This is a datapath property; the arbiter passes values through unmodified.
- Reset (applies at any time, including during HOLD with a pending response):
  - state=IDLE, resp_valid=0, resp_data=0, resp_id=0, ptr=NREQ-1.
  - The pending response is discarded.
  - req_ready=0 during the reset cycle.
- Requests are not sticky: a requester may deassert req_valid before being granted without penalty.

Optional Feature:
- SHIFT_ARB_RR_EN defined: round-robin grant as described.
- SHIFT_ARB_RR_EN undefined:
  - Fixed priority: lowest index wins.
  - ptr register is removed; grant depends only on req_valid.

Decomposition:
- Package shift_arb_pkg holds:
  - op encoding constants OP_SRA=0, OP_SLL=1
  - state enum {IDLE, HOLD}
  - default WIDTH/AMT_W constants
- Sub-module shift_arb_rr:
  - Takes req vector, ptr and enable; outputs one-hot grant and grant index.
  - Contains the priority rotate logic and the SHIFT_ARB_RR_EN switch.
  - The top level holds the FSM, operand muxes and response register.

Test Plan:
- Single request: req0 data=0x80000000, amt=4, op=SRA -> next cycle resp_valid=1, resp_data=0xF8000000, resp_id=0.
- Contention: both valid continuously, resp_ready=1 -> grants 0,1,0,1; req1 data=0x00000001, amt=31, op=SLL yields 0x80000000 with id=1. With the macro off, req0 is granted every cycle.
- Backpressure: resp_ready=0 for 3 cycles while both requesters are valid -> req_ready=0, resp_data stable. Then resp_ready=1 -> accept and a new grant in the same cycle.
- Boundary values:
  - 0x7FFFFFFF SRA 31 -> 0x00000000
  - 0x80000000 SRA 31 -> 0xFFFFFFFF
  - amt=0 -> operand echoed
- Reset mid-HOLD: assert reset while resp_valid=1 -> next cycle resp_valid=0, resp_data=0. The first grant after reset goes to requester 0.
